// File: rtl/divider_pkg.sv
// Shared state encoding and default widths for the iterative divider.
package divider_pkg;

  localparam int DW_DEF    = 16;
  localparam int LOGDW_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_div_step.sv
// One combinational restoring-division step, MSB first.
module div_step #(
  parameter int dw = 16
) (
  input  logic [dw:0]   i_rem,
  input  logic [dw-1:0] i_quo,
  input  logic [dw-1:0] i_div,
  output logic [dw:0]   o_rem,
  output logic [dw-1:0] o_quo
);

  logic [dw:0] w_sh;
  logic [dw:0] w_diff;
  logic        w_unused_top;

  // Remainder stays below the divisor, so its top bit never carries data in.
  assign w_unused_top = i_rem[dw];
  assign w_sh   = {i_rem[dw-1:0], i_quo[dw-1]};
  assign w_diff = w_sh - {1'b0, i_div};

  always_comb begin
    o_rem = w_sh;
    o_quo = {i_quo[dw-2:0], 1'b0};
    if (!w_diff[dw]) begin
      o_rem = w_diff;
      o_quo = {i_quo[dw-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per RDY cycle.
// Define DIV_SIGNED_EN to enable signed divides selected by SGN.
module divider
  import divider_pkg::*;
#(
  parameter int dw    = DW_DEF,
  parameter int logdw = LOGDW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          RDY,
  input  logic          start,
  input  logic          SGN,
  input  logic [dw-1:0] AI,
  input  logic [dw-1:0] BI,
  output logic [dw-1:0] QUO,
  output logic [dw-1:0] REM,
  output logic          busy,
  output logic          done,
  output logic          DZ,
  output logic          V,
  output logic          Z,
  output logic          N
);

  state_t r_state;
  state_t w_state_n;

  logic [logdw-1:0] r_cnt;
  logic [dw:0]      r_prem;
  logic [dw-1:0]    r_qsh;
  logic [dw-1:0]    r_div;
  logic [dw-1:0]    r_ai;
  logic [dw-1:0]    r_quo;
  logic [dw-1:0]    r_rem;
  logic             r_busy;
  logic             r_done;
  logic             r_dz;
  logic             r_z;
  logic             r_n;

  logic [dw:0]      w_prem_n;
  logic [dw-1:0]    w_qsh_n;
  logic [dw-1:0]    w_a_mag;
  logic [dw-1:0]    w_b_mag;
  logic [dw-1:0]    w_q_res;
  logic [dw-1:0]    w_r_res;
  logic             w_bzero;
  logic             w_last;
  logic             w_accept;
  logic             w_step;
  logic             w_wr_run;
  logic             w_wr_dz;
  logic             w_clr;

  div_step #(.dw(dw)) u_step (
    .i_rem (r_prem),
    .i_quo (r_qsh),
    .i_div (r_div),
    .o_rem (w_prem_n),
    .o_quo (w_qsh_n)
  );

  assign w_bzero = (BI == '0);
  assign w_last  = (r_cnt == '0);

`ifdef DIV_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic r_ovf;
  logic r_v;
  logic w_sa;
  logic w_sb;
  logic w_ovf;

  assign w_sa    = SGN & AI[dw-1];
  assign w_sb    = SGN & BI[dw-1];
  assign w_ovf   = SGN && (AI == {1'b1, {(dw-1){1'b0}}})
                 && (BI == '1);
  assign w_a_mag = w_sa ? -AI : AI;
  assign w_b_mag = w_sb ? -BI : BI;
  // Sign fix-up sits on the final step output, so latency is unchanged.
  assign w_q_res = r_neg_q ? -w_qsh_n : w_qsh_n;
  assign w_r_res = r_neg_r ? -w_prem_n[dw-1:0]
                           : w_prem_n[dw-1:0];
  assign V       = r_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
      r_v     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_neg_q <= w_sa ^ w_sb;
        r_neg_r <= w_sa;
        r_ovf   <= w_ovf;
      end
      if (w_wr_run) r_v <= r_ovf;
      if (w_wr_dz)  r_v <= 1'b0;
    end
  end
`else
  logic w_unused_sgn;

  assign w_unused_sgn = SGN;
  assign w_a_mag      = AI;
  assign w_b_mag      = BI;
  assign w_q_res      = w_qsh_n;
  assign w_r_res      = w_prem_n[dw-1:0];
  assign V            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)
                 w_state_n = w_bzero ? S_DONE : S_RUN;
      S_RUN:   if (RDY && w_last) w_state_n = S_DONE;
      S_DONE:  if (RDY && r_done) w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_wr_run = 1'b0;
    w_wr_dz  = 1'b0;
    w_clr    = 1'b0;
    unique case (1'b1)
      (r_state == S_IDLE): w_accept = RDY & start;
      (r_state == S_RUN): begin
        w_step   = RDY;
        w_wr_run = RDY & w_last;
      end
      (r_state == S_DONE): begin
        w_wr_dz = RDY & ~r_done;
        w_clr   = RDY & r_done;
      end
      default: w_accept = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_prem <= '0;
      r_qsh  <= '0;
      r_div  <= '0;
      r_ai   <= '0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_dz   <= 1'b0;
      r_z    <= 1'b1;
      r_n    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_prem <= '0;
        r_qsh  <= w_a_mag;
        r_div  <= w_b_mag;
        r_ai   <= AI;
        r_cnt  <= logdw'(dw-1);
        r_busy <= 1'b1;
      end
      if (w_step) begin
        r_prem <= w_prem_n;
        r_qsh  <= w_qsh_n;
        r_cnt  <= r_cnt - logdw'(1);
      end
      if (w_wr_run) begin
        r_quo  <= w_q_res;
        r_rem  <= w_r_res;
        r_dz   <= 1'b0;
        r_z    <= (w_q_res == '0);
        r_n    <= w_q_res[dw-1];
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_wr_dz) begin
        r_quo  <= '1;
        r_rem  <= r_ai;
        r_dz   <= 1'b1;
        r_z    <= 1'b0;
        r_n    <= 1'b1;
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_clr) r_done <= 1'b0;
    end
  end

  assign QUO  = r_quo;
  assign REM  = r_rem;
  assign busy = r_busy;
  assign done = r_done;
  assign DZ   = r_dz;
  assign Z    = r_z;
  assign N    = r_n;

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter dw, default 16, data width (8 for 6502, 16 for 65Org16).
REQ-002 Parameter logdw, default 4, width of iteration counter (log2 of dw).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RDY  input  1  global advance enable; when low all state, counter and outputs hold.
REQ-006 start  input  1  request a divide; sampled only when idle and RDY high.
REQ-007 SGN  input  1  signed-divide select; ignored unless DIV_SIGNED_EN is defined.
REQ-008 AI  input  dw  dividend, sampled when start is accepted.
REQ-009 BI  input  dw  divisor, sampled when start is accepted.
REQ-010 QUO  output  dw  registered quotient.
REQ-011 REM  output  dw  registered remainder.
REQ-012 busy  output  1  high while a divide is in progress.
REQ-013 done  output  1  result-valid pulse, one RDY cycle.
REQ-014 DZ  output  1  divide-by-zero flag for the last result.
REQ-015 V  output  1  signed overflow flag for the last result.
REQ-016 Z  output  1  QUO == 0 for the last result.
REQ-017 N  output  1  QUO[dw-1] for the last result.

Function
REQ-018 States: IDLE, RUN, DONE. IDLE -> RUN on accepted start with BI != 0. IDLE -> DONE on accepted start with BI == 0. RUN -> DONE after the final step. DONE -> IDLE on the next RDY edge.
REQ-019 Start is accepted at edge E0 when state is IDLE, RDY = 1 and start = 1. AI and BI are latched at E0. The counter is loaded with dw-1.
REQ-020 RUN performs one unsigned restoring step per RDY edge, MSB first: shift the partial remainder left by one, trial-subtract the divisor magnitude, keep the result if it is non-negative, and shift the quotient bit in.
REQ-021 Exactly dw steps run, at E1..Edw. At Edw, QUO/REM/DZ/V/Z/N are written, state goes to DONE, busy falls and done rises.
REQ-022 done stays high for exactly one RDY cycle. QUO/REM/flags hold their values until the next result is written.
REQ-023 busy is high from after E0 until the result-write edge.
REQ-024 start while busy or done is high is ignored; no queuing.
REQ-025 Divide by zero: the result is written at E1 with QUO = all ones, REM = AI, DZ = 1, V = 0. No RUN cycles occur.
REQ-026 DZ = 0 and V = 0 for every non-zero-divisor unsigned result.
REQ-027 RDY low: no state, counter or output change. A high done is held, and the pulse completes on the next RDY-high edge. Latency in clk cycles extends by exactly the number of RDY-low cycles.
REQ-028 All arithmetic is modulo 2^dw. The partial remainder register is dw+1 bits wide to hold the trial-subtract borrow.

Reset
REQ-029 On reset at any edge, including mid-RUN: state = IDLE, counter = 0, and QUO, REM, busy, done, DZ, V, N = 0, Z = 1. Any in-flight divide is discarded.
REQ-030 reset overrides RDY and start.
REQ-031 A start in the first cycle after reset deasserts is accepted normally.

Configuration
REQ-032 Macro DIV_SIGNED_EN. When defined and SGN is latched high at E0:
- operands are converted to magnitudes before the divide;
- QUO is negated if the operand signs differ;
- REM takes the sign of the dividend;
- the fix-up is applied combinationally at the result-write edge, so latency is unchanged.
REQ-033 With DIV_SIGNED_EN and SGN = 1, dividend -2^(dw-1) with divisor -1 yields QUO = -2^(dw-1), REM = 0, V = 1, and takes the normal dw-step latency.
REQ-034 Without DIV_SIGNED_EN, the SGN port still exists and is ignored, all divides are unsigned, and V is constant 0.

Structure
REQ-035 A shared package/include holds the state encodings (IDLE, RUN, DONE) and the default dw/logdw constants.
REQ-036 One sub-module, div_step, implements a single combinational restoring step. divider holds the FSM, counter, operand registers and sign fix-up.
REQ-037 The target size is 120-400 lines of RTL. No multiplier or other divider instance is used.

Verification (dw = 16)
REQ-038 Start with AI = 100, BI = 7, RDY = 1 -> done high in the cycle after E16, QUO = 14, REM = 2, Z = 0, DZ = 0.
REQ-039 Start with AI = 0x1234, BI = 0 -> done after E1, QUO = 0xFFFF, REM = 0x1234, DZ = 1.
REQ-040 AI = 0xFFFF, BI = 1 with RDY low for 5 cycles mid-RUN -> done after E21, QUO = 0xFFFF, REM = 0. A start pulsed during RUN is ignored.
REQ-041 reset asserted at E8 of a divide -> busy = 0, done = 0, QUO = 0, Z = 1. A following 9/3 divide gives QUO = 3, REM = 0.
REQ-042 DIV_SIGNED_EN with SGN = 1:
- -7/2 -> QUO = 0xFFFD, REM = 0xFFFF, N = 1.
- 0x8000/0xFFFF -> QUO = 0x8000, REM = 0, V = 1.
- without the macro, 0x8000/0xFFFF -> QUO = 0, REM = 0x8000, V = 0.
